// File: rtl/pipe_hazard_ctrl.sv
// Central hazard scheduler for a 5-stage F/D/X/M/W pipeline.
// Owns the per-stage valid bits and drives the stage stalls, the D-stage bypass
// selects and the PC-mux select. Counts stall and flush cycles.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rs1_D, rs2_D, use_rs*_D     D-stage source registers and their use flags
//   rd_*, regwen_*              X/M/W destination register and write enable
//   load_X, jal_F, br_taken_D,
//   jalr_X, mem_wait            hazard and redirect sources
//   valid_*                     registered per-stage valid bits
//   stall_*, pc_sel, *_byp_sel  combinational pipeline controls
//   stall_cnt, flush_cnt        saturating performance counters
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic             use_rs1_D,
   input  logic             use_rs2_D,
   input  logic [4:0]       rd_X,
   input  logic [4:0]       rd_M,
   input  logic [4:0]       rd_W,
   input  logic             regwen_X,
   input  logic             regwen_M,
   input  logic             regwen_W,
   input  logic             load_X,
   input  logic             jal_F,
   input  logic             br_taken_D,
   input  logic             jalr_X,
   input  logic             mem_wait,
   output logic             valid_F,
   output logic             valid_D,
   output logic             valid_X,
   output logic             valid_M,
   output logic             valid_W,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_X,
   output logic             stall_M,
   output logic             stall_W,
   output logic [2:0]       pc_sel,
   output logic [1:0]       a_byp_sel,
   output logic [1:0]       b_byp_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned REG_W = 5;

   // A live older instruction writes the (non-zero) register read by D.
   function automatic logic f_hit(input logic v, input logic we,
                                  input logic [REG_W-1:0] rd,
                                  input logic [REG_W-1:0] rs);
      return v & we & (rd == rs) & (rs != REG_W'(0));
   endfunction

   // Youngest producer wins: X over M over W.
   function automatic logic [1:0] f_byp(input logic use_rs, input logic vd,
                                        input logic hx, input logic hm,
                                        input logic hw);
      if (!use_rs || !vd) return 2'd0;
      if (hx)             return 2'd1;
      if (hm)             return 2'd2;
      if (hw)             return 2'd3;
      return 2'd0;
   endfunction

   logic r_valid_F, r_valid_D, r_valid_X, r_valid_M, r_valid_W;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   logic w_hit_x1, w_hit_m1, w_hit_w1, w_hit_x2, w_hit_m2, w_hit_w2;
   logic w_load_stall, w_redir_X, w_redir_D, w_redir_F;
   logic w_stall_inc, w_flush_inc;
   logic w_nxt_F, w_nxt_D, w_nxt_X, w_nxt_M, w_nxt_W;
   logic [4:0] w_stall;
   logic [2:0] w_pc_sel;

   assign w_hit_x1 = f_hit(r_valid_X, regwen_X, rd_X, rs1_D);
   assign w_hit_m1 = f_hit(r_valid_M, regwen_M, rd_M, rs1_D);
   assign w_hit_w1 = f_hit(r_valid_W, regwen_W, rd_W, rs1_D);
   assign w_hit_x2 = f_hit(r_valid_X, regwen_X, rd_X, rs2_D);
   assign w_hit_m2 = f_hit(r_valid_M, regwen_M, rd_M, rs2_D);
   assign w_hit_w2 = f_hit(r_valid_W, regwen_W, rd_W, rs2_D);

   assign a_byp_sel = f_byp(use_rs1_D, r_valid_D, w_hit_x1, w_hit_m1, w_hit_w1);
   assign b_byp_sel = f_byp(use_rs2_D, r_valid_D, w_hit_x2, w_hit_m2, w_hit_w2);

   assign w_load_stall = r_valid_D & r_valid_X & load_X &
                         ((use_rs1_D & w_hit_x1) | (use_rs2_D & w_hit_x2));
   assign w_redir_X    = r_valid_X & jalr_X;
   assign w_redir_D    = r_valid_D & br_taken_D & ~w_load_stall;
   assign w_redir_F    = r_valid_F & jal_F;

   assign w_stall_inc  = mem_wait | w_load_stall;
   assign w_flush_inc  = (w_redir_X | w_redir_D) & ~mem_wait;

   // Prioritised sequencing: freeze, JALR kill, load bubble, branch kill, shift.
   always_comb begin
      w_pc_sel = 3'd0;
      w_stall  = 5'b00000;
      w_nxt_F  = r_valid_F;
      w_nxt_D  = r_valid_D;
      w_nxt_X  = r_valid_X;
      w_nxt_M  = r_valid_M;
      w_nxt_W  = r_valid_W;
      if (mem_wait) begin
         w_stall = 5'b11111;
      end else if (w_redir_X) begin
         w_pc_sel = 3'd2;
         w_nxt_F  = 1'b1;
         w_nxt_D  = 1'b0;
         w_nxt_X  = 1'b0;
         w_nxt_M  = 1'b1;
         w_nxt_W  = r_valid_M;
      end else if (w_load_stall) begin
         // F and D hold; a bubble enters X.
         w_stall  = 5'b00011;
         w_nxt_F  = 1'b1;
         w_nxt_X  = 1'b0;
         w_nxt_M  = r_valid_X;
         w_nxt_W  = r_valid_M;
      end else if (w_redir_D) begin
         w_pc_sel = 3'd3;
         w_nxt_F  = 1'b1;
         w_nxt_D  = 1'b0;
         w_nxt_X  = r_valid_D;
         w_nxt_M  = r_valid_X;
         w_nxt_W  = r_valid_M;
      end else begin
         // JAL redirects at this edge, so the fetched-next slot is already right.
         w_pc_sel = w_redir_F ? 3'd1 : 3'd0;
         w_nxt_F  = 1'b1;
         w_nxt_D  = r_valid_F;
         w_nxt_X  = r_valid_D;
         w_nxt_M  = r_valid_X;
         w_nxt_W  = r_valid_M;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_F   <= 1'b0;
         r_valid_D   <= 1'b0;
         r_valid_X   <= 1'b0;
         r_valid_M   <= 1'b0;
         r_valid_W   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_valid_F <= w_nxt_F;
         r_valid_D <= w_nxt_D;
         r_valid_X <= w_nxt_X;
         r_valid_M <= w_nxt_M;
         r_valid_W <= w_nxt_W;
         if (w_stall_inc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_inc && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign valid_F   = r_valid_F;
   assign valid_D   = r_valid_D;
   assign valid_X   = r_valid_X;
   assign valid_M   = r_valid_M;
   assign valid_W   = r_valid_W;
   assign stall_F   = w_stall[0];
   assign stall_D   = w_stall[1];
   assign stall_X   = w_stall[2];
   assign stall_M   = w_stall[3];
   assign stall_W   = w_stall[4];
   assign pc_sel    = w_pc_sel;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random stimulus, checked
// against a behavioural model of the pipeline valids and counters. A second
// instance with 2-bit counters exercises saturation.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1_D, rs2_D, rd_X, rd_M, rd_W;
   logic       use_rs1_D, use_rs2_D, regwen_X, regwen_M, regwen_W;
   logic       load_X, jal_F, br_taken_D, jalr_X, mem_wait;

   logic       valid_F, valid_D, valid_X, valid_M, valid_W;
   logic       stall_F, stall_D, stall_X, stall_M, stall_W;
   logic [2:0] pc_sel;
   logic [1:0] a_byp_sel, b_byp_sel;
   logic [15:0] stall_cnt, flush_cnt;

   logic       s_valid_F, s_valid_D, s_valid_X, s_valid_M, s_valid_W;
   logic       s_stall_F, s_stall_D, s_stall_X, s_stall_M, s_stall_W;
   logic [2:0] s_pc_sel;
   logic [1:0] s_a_byp_sel, s_b_byp_sel;
   logic [1:0] s_stall_cnt, s_flush_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: index 0 = F ... 4 = W.
   bit mv [5];
   int m_stall, m_flush, m_stall_s, m_flush_s;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
      .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .rd_X(rd_X), .rd_M(rd_M), .rd_W(rd_W),
      .regwen_X(regwen_X), .regwen_M(regwen_M), .regwen_W(regwen_W),
      .load_X(load_X), .jal_F(jal_F), .br_taken_D(br_taken_D),
      .jalr_X(jalr_X), .mem_wait(mem_wait),
      .valid_F(valid_F), .valid_D(valid_D), .valid_X(valid_X),
      .valid_M(valid_M), .valid_W(valid_W),
      .stall_F(stall_F), .stall_D(stall_D), .stall_X(stall_X),
      .stall_M(stall_M), .stall_W(stall_W),
      .pc_sel(pc_sel), .a_byp_sel(a_byp_sel), .b_byp_sel(b_byp_sel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   pipe_hazard_ctrl #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
      .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .rd_X(rd_X), .rd_M(rd_M), .rd_W(rd_W),
      .regwen_X(regwen_X), .regwen_M(regwen_M), .regwen_W(regwen_W),
      .load_X(load_X), .jal_F(jal_F), .br_taken_D(br_taken_D),
      .jalr_X(jalr_X), .mem_wait(mem_wait),
      .valid_F(s_valid_F), .valid_D(s_valid_D), .valid_X(s_valid_X),
      .valid_M(s_valid_M), .valid_W(s_valid_W),
      .stall_F(s_stall_F), .stall_D(s_stall_D), .stall_X(s_stall_X),
      .stall_M(s_stall_M), .stall_W(s_stall_W),
      .pc_sel(s_pc_sel), .a_byp_sel(s_a_byp_sel), .b_byp_sel(s_b_byp_sel),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

   // ---------------- reference model ----------------
   function automatic bit m_hit(int stage, logic [4:0] r);
      case (stage)
         2:       return mv[2] && regwen_X && rd_X == r && r != 0;
         3:       return mv[3] && regwen_M && rd_M == r && r != 0;
         default: return mv[4] && regwen_W && rd_W == r && r != 0;
      endcase
   endfunction

   function automatic int m_byp(bit use_rs, logic [4:0] rs);
      if (!use_rs || rs == 0 || !mv[1]) return 0;
      for (int s = 2; s <= 4; s++) if (m_hit(s, rs)) return s - 1;
      return 0;
   endfunction

   function automatic bit m_ls();
      return mv[1] && mv[2] && load_X &&
             ((use_rs1_D && m_hit(2, rs1_D)) || (use_rs2_D && m_hit(2, rs2_D)));
   endfunction

   function automatic bit m_rx(); return mv[2] && jalr_X; endfunction
   function automatic bit m_rd(); return mv[1] && br_taken_D && !m_ls(); endfunction

   function automatic int m_pc();
      if (mem_wait) return 0;
      if (m_rx())   return 2;
      if (m_ls())   return 0;
      if (m_rd())   return 3;
      if (mv[0] && jal_F) return 1;
      return 0;
   endfunction

   function automatic logic [4:0] m_stalls();
      if (mem_wait) return 5'b11111;
      if (!m_rx() && m_ls()) return 5'b00011;
      return 5'b00000;
   endfunction

   function automatic logic [4:0] m_vec();
      return {mv[4], mv[3], mv[2], mv[1], mv[0]};
   endfunction

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) mv[i] = 0;
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
   endtask

   task automatic clear_inputs();
      rs1_D = 0; rs2_D = 0; use_rs1_D = 0; use_rs2_D = 0;
      rd_X = 0; rd_M = 0; rd_W = 0; regwen_X = 0; regwen_M = 0; regwen_W = 0;
      load_X = 0; jal_F = 0; br_taken_D = 0; jalr_X = 0; mem_wait = 0;
   endtask

   // One clock cycle: check combinational outputs, advance model across edge,
   // then check registered state.
   task automatic step(string tag);
      bit nv [5];
      bit ls, rx, rd;
      #1;
      n_checks++;
      if ({a_byp_sel, b_byp_sel} !== {2'(m_byp(use_rs1_D, rs1_D)), 2'(m_byp(use_rs2_D, rs2_D))})
         $display("FAIL %s byp: got a=%0d b=%0d want a=%0d b=%0d", tag, a_byp_sel, b_byp_sel,
                  m_byp(use_rs1_D, rs1_D), m_byp(use_rs2_D, rs2_D));
      else n_pass++;
      n_checks++;
      if (pc_sel !== 3'(m_pc()))
         $display("FAIL %s pc_sel: got %0d want %0d", tag, pc_sel, m_pc());
      else n_pass++;
      n_checks++;
      if ({stall_W, stall_M, stall_X, stall_D, stall_F} !== m_stalls())
         $display("FAIL %s stalls: got %b want %b", tag,
                  {stall_W, stall_M, stall_X, stall_D, stall_F}, m_stalls());
      else n_pass++;
      ls = m_ls(); rx = m_rx(); rd = m_rd();
      // Default: everything advances one stage and F refetches.
      nv[0] = 1; nv[1] = mv[0]; nv[2] = mv[1]; nv[3] = mv[2]; nv[4] = mv[3];
      if (mem_wait)  for (int i = 0; i < 5; i++) nv[i] = mv[i];
      else if (rx)   begin nv[1] = 0; nv[2] = 0; nv[3] = 1; end
      else if (ls)   begin nv[1] = mv[1]; nv[2] = 0; end
      else if (rd)   nv[1] = 0;
      if (mem_wait || ls) begin m_stall++; m_stall_s = sat(m_stall_s + 1, 3); end
      if ((rx || rd) && !mem_wait) begin m_flush++; m_flush_s = sat(m_flush_s + 1, 3); end
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) mv[i] = nv[i];
      n_checks++;
      if ({valid_W, valid_M, valid_X, valid_D, valid_F} !== m_vec())
         $display("FAIL %s valids: got %b want %b", tag,
                  {valid_W, valid_M, valid_X, valid_D, valid_F}, m_vec());
      else n_pass++;
      n_checks++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) ||
          s_stall_cnt !== 2'(m_stall_s) || s_flush_cnt !== 2'(m_flush_s))
         $display("FAIL %s counters: got %0d/%0d sat %0d/%0d want %0d/%0d sat %0d/%0d", tag,
                  stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt,
                  m_stall, m_flush, m_stall_s, m_flush_s);
      else n_pass++;
   endtask

   // Mid-cycle asynchronous reset, then fill the pipe with idle instructions.
   task automatic pulse_reset();
      rst_n = 0;
      #2;
      model_reset();
      rst_n = 1;
   endtask

   task automatic fill_pipe();
      clear_inputs();
      pulse_reset();
      for (int i = 0; i < 5; i++) step("fill");
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_inputs();
      for (int i = 0; i < 3; i++) step("pre_reset");
      rst_n = 0;
      #2;
      n_checks++;
      if ({valid_W, valid_M, valid_X, valid_D, valid_F} !== 5'b0 || stall_cnt !== 16'd0 ||
          flush_cnt !== 16'd0)
         $display("FAIL reset_async: valids=%b cnt=%0d/%0d want 0", 
                  {valid_W, valid_M, valid_X, valid_D, valid_F}, stall_cnt, flush_cnt);
      else n_pass++;
      model_reset();
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         step("reset_fill");
         if (i == 0) begin
            n_checks++;
            if (valid_F !== 1'b1 || valid_D !== 1'b0)
               $display("FAIL reset_first_edge: F=%b D=%b want F=1 D=0", valid_F, valid_D);
            else n_pass++;
         end
      end
      n_checks++;
      if (valid_W !== 1'b1) $display("FAIL reset_fifth_edge: valid_W=%b want 1", valid_W);
      else n_pass++;
   endtask

   task automatic test_bypass();
      int want [4] = '{1, 2, 3, 0};
      fill_pipe();
      use_rs1_D = 1; rs1_D = 5; rd_X = 5; rd_M = 5; rd_W = 5;
      regwen_X = 1; regwen_M = 1; regwen_W = 1;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) regwen_X = 0;
         if (k == 2) regwen_M = 0;
         if (k == 3) rs1_D = 0;
         #1;
         n_checks++;
         if (a_byp_sel !== 2'(want[k]))
            $display("FAIL bypass_prio_%0d: a_byp_sel=%0d want %0d", k, a_byp_sel, want[k]);
         else n_pass++;
      end
      step("bypass");
   endtask

   task automatic test_load_use();
      fill_pipe();
      rd_X = 3; regwen_X = 1; load_X = 1; rs1_D = 3; use_rs1_D = 1;
      #1;
      n_checks++;
      if (stall_F !== 1'b1 || stall_D !== 1'b1 || stall_X !== 1'b0 || pc_sel !== 3'd0)
         $display("FAIL load_use_stall: F=%b D=%b X=%b pc=%0d want 1 1 0 0",
                  stall_F, stall_D, stall_X, pc_sel);
      else n_pass++;
      step("load_use");
      n_checks++;
      if (valid_X !== 1'b0) $display("FAIL load_use_bubble: valid_X=%b want 0", valid_X);
      else n_pass++;
      // Load now sits in M; X is the bubble.
      rd_X = 0; regwen_X = 0; load_X = 0; rd_M = 3; regwen_M = 1;
      #1;
      n_checks++;
      if (a_byp_sel !== 2'd2 || stall_F !== 1'b0 || stall_D !== 1'b0)
         $display("FAIL load_use_after: byp=%0d stallF=%b stallD=%b want 2 0 0",
                  a_byp_sel, stall_F, stall_D);
      else n_pass++;
      step("load_use_after");
      n_checks++;
      if (stall_cnt !== 16'd1) $display("FAIL load_use_cnt: stall_cnt=%0d want 1", stall_cnt);
      else n_pass++;
   endtask

   task automatic test_branch();
      fill_pipe();
      br_taken_D = 1;
      #1;
      n_checks++;
      if (pc_sel !== 3'd3) $display("FAIL branch_pc: pc_sel=%0d want 3", pc_sel);
      else n_pass++;
      step("branch");
      n_checks++;
      if (valid_D !== 1'b0 || valid_X !== 1'b1 || flush_cnt !== 16'd1)
         $display("FAIL branch_kill: D=%b X=%b flush=%0d want 0 1 1", valid_D, valid_X, flush_cnt);
      else n_pass++;
   endtask

   task automatic test_jalr();
      fill_pipe();
      rd_X = 7; regwen_X = 1; load_X = 1; rs2_D = 7; use_rs2_D = 1;
      br_taken_D = 1; jalr_X = 1;
      #1;
      n_checks++;
      if (pc_sel !== 3'd2 || {stall_W, stall_M, stall_X, stall_D, stall_F} !== 5'b0)
         $display("FAIL jalr_prio: pc=%0d stalls=%b want 2 00000", pc_sel,
                  {stall_W, stall_M, stall_X, stall_D, stall_F});
      else n_pass++;
      step("jalr");
      n_checks++;
      if (valid_D !== 1'b0 || valid_X !== 1'b0 || valid_M !== 1'b1 || flush_cnt !== 16'd1)
         $display("FAIL jalr_kill: D=%b X=%b M=%b flush=%0d want 0 0 1 1",
                  valid_D, valid_X, valid_M, flush_cnt);
      else n_pass++;
   endtask

   task automatic test_jal();
      fill_pipe();
      jal_F = 1;
      #1;
      n_checks++;
      if (pc_sel !== 3'd1) $display("FAIL jal_pc: pc_sel=%0d want 1", pc_sel);
      else n_pass++;
      step("jal");
      n_checks++;
      if (valid_D !== 1'b1 || flush_cnt !== 16'd0)
         $display("FAIL jal_nokill: D=%b flush=%0d want 1 0", valid_D, flush_cnt);
      else n_pass++;
   endtask

   task automatic test_mem_wait();
      fill_pipe();
      mem_wait = 1; br_taken_D = 1; jal_F = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if ({stall_W, stall_M, stall_X, stall_D, stall_F} !== 5'b11111 || pc_sel !== 3'd0)
            $display("FAIL mem_wait_stall_%0d: stalls=%b pc=%0d want 11111 0", i,
                     {stall_W, stall_M, stall_X, stall_D, stall_F}, pc_sel);
         else n_pass++;
         step("mem_wait");
      end
      n_checks++;
      if ({valid_W, valid_M, valid_X, valid_D, valid_F} !== 5'b11111 || stall_cnt !== 16'd3 ||
          flush_cnt !== 16'd0)
         $display("FAIL mem_wait_end: valids=%b stall=%0d flush=%0d want 11111 3 0",
                  {valid_W, valid_M, valid_X, valid_D, valid_F}, stall_cnt, flush_cnt);
      else n_pass++;
   endtask

   task automatic test_saturation();
      fill_pipe();
      mem_wait = 1;
      for (int i = 0; i < 6; i++) step("saturate");
      n_checks++;
      if (s_stall_cnt !== 2'd3 || stall_cnt !== 16'd6)
         $display("FAIL saturation: narrow=%0d wide=%0d want 3 6", s_stall_cnt, stall_cnt);
      else n_pass++;
      mem_wait = 0; br_taken_D = 1;
      for (int i = 0; i < 5; i++) step("saturate_flush");
      n_checks++;
      if (s_flush_cnt !== 2'd3 || s_stall_cnt !== 2'd3)
         $display("FAIL saturation_flush: flush=%0d stall=%0d want 3 3", s_flush_cnt, s_stall_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      fill_pipe();
      for (int i = 0; i < 600; i++) begin
         rs1_D = 5'($urandom_range(0, 3));   rs2_D = 5'($urandom_range(0, 3));
         rd_X  = 5'($urandom_range(0, 3));   rd_M  = 5'($urandom_range(0, 3));
         rd_W  = 5'($urandom_range(0, 3));
         use_rs1_D = 1'($urandom_range(0, 1)); use_rs2_D = 1'($urandom_range(0, 1));
         regwen_X  = 1'($urandom_range(0, 1)); regwen_M  = 1'($urandom_range(0, 1));
         regwen_W  = 1'($urandom_range(0, 1)); load_X    = 1'($urandom_range(0, 1));
         jal_F      = ($urandom_range(0, 3) == 0);
         br_taken_D = ($urandom_range(0, 3) == 0);
         jalr_X     = ($urandom_range(0, 7) == 0);
         mem_wait   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 99) == 0) pulse_reset();
         step("random");
      end
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst_n = 0;
      #12;
      rst_n = 1;
      @(posedge clk);
      #1;
      model_reset();
      mv[0] = 1;
      test_reset();
      test_bypass();
      test_load_use();
      test_branch();
      test_jalr();
      test_jal();
      test_mem_wait();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard scheduler for the 5-stage RISC-V pipeline (F/D/X/M/W).
- Owns the per-stage valid bits and drives stage stalls, D-stage bypass-mux selects and the PC-mux select.
- Sequences load-use bubbles, control-flow redirects/kills and data-memory wait freezes.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs1_D  in  5  rs1 field of D instruction
- rs2_D  in  5  rs2 field of D instruction
- use_rs1_D  in  1  D instruction reads rs1
- use_rs2_D  in  1  D instruction reads rs2
- rd_X, rd_M, rd_W  in  5 each  rd field of the X/M/W instruction
- regwen_X, regwen_M, regwen_W  in  1 each  X/M/W instruction writes the register file
- load_X  in  1  X instruction is a load
- jal_F  in  1  F instruction is JAL (target PC+imm computed in F)
- br_taken_D  in  1  D instruction is a branch resolved taken
- jalr_X  in  1  X instruction is JALR (target on ALU output)
- mem_wait  in  1  data memory is not ready; freeze the whole pipeline
- valid_F, valid_D, valid_X, valid_M, valid_W  out  1 each  stage holds a live instruction
- stall_F, stall_D, stall_X, stall_M, stall_W  out  1 each  stage register holds its value
- pc_sel  out  3  PC mux select: 0 = PC+4, 1 = PCF+immF, 2 = ALU out X, 3 = PCD+immD
- a_byp_sel, b_byp_sel  out  2 each  bypass select: 0 = regfile, 1 = X ALU out, 2 = M writeback, 3 = W writeback
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (rst_n low, asynchronous, including mid-operation):
  - All valid_* = 0 and both counters = 0.
  - valid_F rises at the first clk edge after rst_n deasserts.
  - All other outputs are combinational and follow the rules below using the cleared valids.
- Hit definitions:
  - hitX(r) = valid_X & regwen_X & rd_X == r & r != 0. hitM and hitW are defined the same way.
- Bypass selection (combinational), for a_byp_sel using rs1_D/use_rs1_D (b_byp_sel uses rs2):
  - If use = 0, rs = 0 or valid_D = 0: select 0.
  - Otherwise: hitX gives 1, else hitM gives 2, else hitW gives 3, else 0.
  - Priority is X > M > W.
- Load-use hazard:
  - load_stall = valid_D & valid_X & load_X & ((use_rs1_D & hitX(rs1_D)) | (use_rs2_D & hitX(rs2_D))).
- Redirect conditions:
  - redir_X = valid_X & jalr_X
  - redir_D = valid_D & br_taken_D & ~load_stall
  - redir_F = valid_F & jal_F
- pc_sel, evaluated in priority order:
  - mem_wait: 0.
  - redir_X: 2.
  - load_stall: 0 (PC held by stall_F).
  - redir_D: 3.
  - redir_F: 1.
  - else: 0.
- Stalls and valid update on each clk edge, evaluated in priority order:
  - mem_wait: all stall_* = 1; all valids hold; the counters are still updated.
  - redir_X:
    - No stalls; load_stall is overridden.
    - valid_D <= 0, valid_X <= 0 (the F and D wrong-path instructions are killed).
    - valid_M <= 1, valid_W <= valid_M.
  - load_stall:
    - stall_F = stall_D = 1; valid_D holds.
    - valid_X <= 0 (bubble); valid_M <= valid_X; valid_W <= valid_M.
  - redir_D: valid_D <= 0 (F wrong-path killed); valid_X <= valid_D; M and W shift.
  - otherwise: normal shift valid_D <= valid_F, valid_X <= valid_D, and so on.
  - JAL in F needs no kill, because the redirect takes effect at the same edge.
  - valid_F <= 1 in every case except mem_wait.
- Counters:
  - stall_cnt += 1 on each cycle with mem_wait | load_stall.
  - flush_cnt += 1 on each cycle with (redir_X | redir_D) & ~mem_wait.
  - Both saturate at 2^CNT_W - 1; they never wrap.

Test Plan:
- Reset mid-run: rst_n pulsed low between edges -> valids and counters are 0 immediately; valid_F = 1 after the first edge, valid_W = 1 after the 5th edge.
- Bypass priority: rs1_D = 5 with X, M and W all valid writing x5 -> a_byp_sel = 1. X's regwen dropped -> 2. M's regwen then dropped -> 3. rs1_D = 0 -> 0.
- Load-use: lw x3 in X, add using x3 in D -> one cycle with stall_F = stall_D = 1, pc_sel = 0, then valid_X = 0 at the next edge. The following cycle has a_byp_sel = 2 and no stall; stall_cnt = 1.
- Branch taken in D -> pc_sel = 3, valid_D = 0 at the next edge, flush_cnt = 1.
- JALR in X coinciding with load_stall and br_taken_D -> pc_sel = 2, no stall, valid_D = valid_X = 0 at the next edge, flush_cnt increments by 1.
- mem_wait held 3 cycles -> all stall_* = 1 and valids frozen for 3 cycles; stall_cnt = 3.
- Saturation (CNT_W = 2): mem_wait held for 6 cycles -> stall_cnt stops at 3.
